// File: rtl/stream_mux_rr_pkg.sv
// ============================================================================
// stream_mux_rr_pkg : shared types and helpers for the round-robin stream mux
// Revision: 1.0
// ============================================================================
`default_nettype none

package stream_mux_rr_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Width of a channel index / pointer for n channels.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stream_mux_rr_rr_arbiter.sv
// ============================================================================
// rr_arbiter : grants the first requester after ptr, wrapping modulo N_CH
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
  import stream_mux_rr_pkg::*;
#(
  parameter int N_CH = 4
) (
  input  logic [N_CH-1:0]          req,
  input  logic [ptr_w(N_CH)-1:0]   ptr,
  output logic [ptr_w(N_CH)-1:0]   grant,
  output logic                     grant_valid
);

  localparam int PW = ptr_w(N_CH);

  int idx;

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int i = 1; i <= N_CH; i++) begin
      idx = (int'(ptr) + i) % N_CH;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant       = idx[PW-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/stream_mux_rr.sv
// ============================================================================
// stream_mux_rr : N_CH-to-1 round-robin stream mux with a 1-deep output register
// Optional packet locking: define STREAM_MUX_RR_LAST_LOCK_EN.  Revision: 1.0
// ============================================================================
`default_nettype none

module stream_mux_rr
  import stream_mux_rr_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int W    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          in_valid,
  input  logic [N_CH*W-1:0]        in_data,
  input  logic [N_CH-1:0]          in_last,
  output logic [N_CH-1:0]          in_ready,
  output logic                     out_valid,
  output logic [W-1:0]             out_data,
  output logic [$clog2(N_CH)-1:0]  out_ch,
  output logic                     out_last,
  input  logic                     out_ready
);

  localparam int PW = ptr_w(N_CH);

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   grant;
  logic            grant_valid;
  logic [N_CH-1:0] req;
  logic            out_free;
  logic            in_xfer;
  logic [W-1:0]    sel_data;
  logic            sel_last;

`ifdef STREAM_MUX_RR_LAST_LOCK_EN
  state_t        state, state_nx;
  logic [PW-1:0] lock_ch, lock_ch_nx;

  // While locked, only the locked channel may request, valid or not.
  always_comb begin
    req = in_valid;
    if (state == LOCKED) begin
      req          = '0;
      req[lock_ch] = in_valid[lock_ch];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      lock_ch <= '0;
    end else begin
      state   <= state_nx;
      lock_ch <= lock_ch_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    lock_ch_nx = lock_ch;
    case (state)
      IDLE: begin
        if (in_xfer && !sel_last) begin
          state_nx   = LOCKED;
          lock_ch_nx = grant;
        end
      end
      LOCKED: begin
        if (in_xfer && sel_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
`else
  assign req = in_valid;
`endif

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req         (req),
    .ptr         (ptr),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  assign out_free = !out_valid || out_ready;
  assign in_xfer  = !rst && grant_valid && out_free;
  assign sel_data = in_data[int'(grant)*W +: W];
  assign sel_last = in_last[grant];

  always_comb begin
    in_ready = '0;
    if (in_xfer) in_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_last  <= 1'b0;
      ptr       <= PW'(N_CH - 1);
    end else if (in_xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_ch    <= grant;
      out_last  <= sel_last;
      ptr       <= grant;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
// ============================================================================
// tb_stream_mux_rr : scoreboard bench for stream_mux_rr (directed + random)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_stream_mux_rr;
  import stream_mux_rr_pkg::*;

  localparam int N_CH = 4;
  localparam int W    = 4;
  localparam int PW   = ptr_w(N_CH);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N_CH-1:0]   in_valid = '0;
  logic [N_CH*W-1:0] in_data = '0;
  logic [N_CH-1:0]   in_last = '0;
  logic [N_CH-1:0]   in_ready;
  logic              out_valid;
  logic [W-1:0]      out_data;
  logic [PW-1:0]     out_ch;
  logic              out_last;
  logic              out_ready = 1'b0;

  stream_mux_rr #(.N_CH(N_CH), .W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_ch(out_ch), .out_last(out_last),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  d;
    logic [PW-1:0] ch;
    logic          l;
  } beat_t;

  beat_t sb_q[$];
  int    seen_ch[$];
  int    checks = 0;
  int    errors = 0;
  bit    mon_en = 1'b0;

  // Reference state: last granted channel and packet lock.
  int ptr_m    = N_CH - 1;
  bit locked_m = 1'b0;
  int lock_m   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: output side, 1 time unit after the stimulus edge.
  always @(negedge clk) begin
    #1;
    if (mon_en) begin
      checks++;
      if (out_valid !== (sb_q.size() != 0)) begin
        errors++;
        $display("FAIL out_valid: got %b expected %b at %0t", out_valid, sb_q.size() != 0, $time);
      end
      if (out_valid === 1'b1 && out_ready && sb_q.size() != 0) begin
        beat_t e;
        e = sb_q.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_ch", out_ch, e.ch);
        chk("out_last", out_last, e.l);
        seen_ch.push_back(int'(out_ch));
      end
    end
  end

  // Reference model: who should be accepted this cycle.
  task automatic model();
    logic [N_CH-1:0] exp_rdy;
    int g;
    exp_rdy = '0;
    g = -1;
    if (rst) begin
      sb_q.delete();
      ptr_m    = N_CH - 1;
      locked_m = 1'b0;
    end else if (sb_q.size() == 0) begin
      if (locked_m) begin
        if (in_valid[lock_m]) g = lock_m;
      end else begin
        for (int k = 1; k <= N_CH; k++)
          if (g < 0 && in_valid[(ptr_m + k) % N_CH]) g = (ptr_m + k) % N_CH;
      end
      if (g >= 0) begin
        beat_t b;
        exp_rdy[g] = 1'b1;
        b.d  = in_data[g*W +: W];
        b.ch = PW'(g);
        b.l  = in_last[g];
        sb_q.push_back(b);
        ptr_m = g;
`ifdef STREAM_MUX_RR_LAST_LOCK_EN
        if (!locked_m && !in_last[g]) begin
          locked_m = 1'b1;
          lock_m   = g;
        end else if (locked_m && in_last[g]) begin
          locked_m = 1'b0;
        end
`endif
      end
    end
    if (mon_en) chk("in_ready", in_ready, exp_rdy);
  endtask

  task automatic step(input logic r, input logic [N_CH-1:0] v,
                      input logic [N_CH*W-1:0] d, input logic [N_CH-1:0] l,
                      input logic ordy);
    @(negedge clk);
    rst = r; in_valid = v; in_data = d; in_last = l; out_ready = ordy;
    #2;
    model();
  endtask

  task automatic do_reset();
    step(1'b1, '0, '0, '0, 1'b0);
    step(1'b1, '0, '0, '0, 1'b0);
  endtask

  initial begin
    do_reset();
    mon_en = 1'b1;
    // Reset state of the output register.
    step(1'b0, '0, '0, '0, 1'b0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_in_ready", in_ready, 0);

    // All valid, out_ready held high: 0,1,2,3,0 back to back.
    seen_ch.delete();
    for (int i = 0; i < 5; i++) step(1'b0, 4'hF, 16'hDCBA, 4'hF, 1'b1);
    step(1'b0, '0, '0, '0, 1'b1);
    chk("rr_seq_len", seen_ch.size(), 5);
    for (int i = 0; i < 5 && i < seen_ch.size(); i++)
      chk("rr_seq_ch", seen_ch[i], i % 4);

    // Only channel 2 valid with data 5, then ptr=2 so channel 3 is next.
    do_reset();
    step(1'b0, 4'b0100, 16'h0500, 4'hF, 1'b1);
    step(1'b0, 4'hF, 16'h4321, 4'hF, 1'b1);
    chk("ch2_in_ready", in_ready, 4'b1000);
    step(1'b0, '0, '0, '0, 1'b1);

    // Backpressure: beat 7 held for 3 cycles, no in_ready.
    step(1'b0, 4'b0001, 16'h0007, 4'hF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'hF, 16'h1111, 4'hF, 1'b0);
      chk("hold_out_data", out_data, 7);
      chk("hold_in_ready", in_ready, 0);
    end
    step(1'b0, '0, '0, '0, 1'b1);
    step(1'b0, '0, '0, '0, 1'b1);

    // Reset while a beat is held: beat discarded, channel 0 first afterwards.
    step(1'b0, 4'b0010, 16'h00A0, 4'hF, 1'b0);
    step(1'b1, 4'hF, 16'h1234, 4'hF, 1'b0);
    chk("rst_mid_in_ready", in_ready, 0);
    step(1'b0, 4'hF, 16'h1234, 4'hF, 1'b1);
    chk("post_rst_valid", out_valid, 0);
    chk("post_rst_grant", in_ready, 4'b0001);

    // Wrap-around: ptr=3, channels 0 and 3 valid -> channel 0.
    step(1'b0, 4'b1000, 16'h9000, 4'hF, 1'b1);
    step(1'b0, 4'b1001, 16'h9008, 4'hF, 1'b1);
    chk("wrap_grant", in_ready, 4'b0001);
    step(1'b0, '0, '0, '0, 1'b1);

`ifdef STREAM_MUX_RR_LAST_LOCK_EN
    // Channel 1 holds the mux for a 3-beat packet while channel 0 waits.
    do_reset();
    step(1'b0, 4'b0001, 16'h0003, 4'b0001, 1'b1);
    seen_ch.delete();
    step(1'b0, 4'b0011, 16'h0014, 4'b0001, 1'b1);
    step(1'b0, 4'b0011, 16'h0024, 4'b0001, 1'b1);
    step(1'b0, 4'b0011, 16'h0034, 4'b0011, 1'b1);
    step(1'b0, 4'b0001, 16'h0004, 4'b0001, 1'b1);
    step(1'b0, '0, '0, '0, 1'b1);
    chk("lock_seq_len", seen_ch.size(), 5);
    if (seen_ch.size() == 5) begin
      chk("lock_seq0", seen_ch[0], 0);
      chk("lock_seq1", seen_ch[1], 1);
      chk("lock_seq2", seen_ch[2], 1);
      chk("lock_seq3", seen_ch[3], 1);
      chk("lock_seq4", seen_ch[4], 0);
    end
`endif

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) == 0),
           N_CH'($urandom()),
           (N_CH*W)'($urandom()),
           N_CH'($urandom()),
           ($urandom_range(0, 3) != 0));
    end
    step(1'b0, '0, '0, '0, 1'b1);
    step(1'b0, '0, '0, '0, 1'b1);
    chk("drain_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
